logic_unit_pipe: RTL and testbench

LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

---
 rtl/logic_unit_pipe_if.sv | 28 ++
 rtl/logic_unit_pipe.sv | 125 ++++++++++++
 tb/tb_logic_unit_pipe.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/logic_unit_pipe_if.sv
// Handshake and data bundle between an upstream source, the logic unit and a
// downstream sink. The slave modport is the logic unit's view.
interface logic_unit_pipe_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
);
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       OP;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] Y;
  logic             ZERO;
  logic             PARITY;
  logic [CNT_W-1:0] COUNT;

  modport master (
    output IN_VALID, A, B, OP, OUT_READY,
    input  IN_READY, OUT_VALID, Y, ZERO, PARITY, COUNT
  );

  modport slave (
    input  IN_VALID, A, B, OP, OUT_READY,
    output IN_READY, OUT_VALID, Y, ZERO, PARITY, COUNT
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready pipelined bitwise logic unit with an XOR accumulator,
// registered zero/parity flags and a wrapping count of delivered results.
module logic_unit_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic               CLK,
  input  logic               RST,
  logic_unit_pipe_if.slave   bus
);

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_NAND = 3'd1,
    OP_OR   = 3'd2,
    OP_NOR  = 3'd3,
    OP_NOT  = 3'd4,
    OP_XOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_ACC  = 3'd7
  } op_e;

  // Stage 1: captured operands
  logic             s1_v_q;
  logic [WIDTH-1:0] a_s1_q;
  logic [WIDTH-1:0] b_s1_q;
  op_e              op_s1_q;

  // Stage 2: registered result and flags
  logic             out_valid_q;
  logic [WIDTH-1:0] y_q;
  logic             zero_q;
  logic             parity_q;

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] y_d;
  logic [CNT_W-1:0] count_q;

  logic s2_ready;
  logic in_ready;
  logic in_fire;
  logic advance;
  logic out_fire;

  // The only combinational input-to-output path is OUT_READY -> IN_READY.
  assign s2_ready = !out_valid_q || bus.OUT_READY;
  assign in_ready = !s1_v_q || s2_ready;
  assign in_fire  = bus.IN_VALID && in_ready;
  assign advance  = s1_v_q && s2_ready;
  assign out_fire = out_valid_q && bus.OUT_READY;

  always_comb begin
    y_d   = '0;
    acc_d = acc_q;
    unique case (op_s1_q)
      OP_AND:  y_d = a_s1_q & b_s1_q;
      OP_NAND: y_d = ~(a_s1_q & b_s1_q);
      OP_OR:   y_d = a_s1_q | b_s1_q;
      OP_NOR:  y_d = ~(a_s1_q | b_s1_q);
      OP_NOT:  y_d = ~a_s1_q;
      OP_XOR:  y_d = a_s1_q ^ b_s1_q;
      OP_XNOR: y_d = ~(a_s1_q ^ b_s1_q);
      OP_ACC: begin
        acc_d = acc_q ^ a_s1_q;
        y_d   = acc_d;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_v_q <= 1'b0;
    end else if (in_ready) begin
      s1_v_q <= bus.IN_VALID;
    end
  end

  // NOTE: the stage-1 payload has no reset; s1_v_q alone qualifies it.
  always_ff @(posedge CLK) begin
    if (in_fire) begin
      a_s1_q  <= bus.A;
      b_s1_q  <= bus.B;
      op_s1_q <= op_e'(bus.OP);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      zero_q      <= 1'b1;
      parity_q    <= 1'b0;
      acc_q       <= '0;
    end else begin
      if (s2_ready) begin
        out_valid_q <= s1_v_q;
      end
      if (advance) begin
        y_q      <= y_d;
        zero_q   <= ~|y_d;
        parity_q <= ^y_d;
        acc_q    <= acc_d;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0;
    end else if (out_fire) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign bus.IN_READY  = in_ready;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.Y         = y_q;
  assign bus.ZERO      = zero_q;
  assign bus.PARITY    = parity_q;
  assign bus.COUNT     = count_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed self-checking bench for logic_unit_pipe: ops, accumulator,
// back-pressure, streaming, reset flush and counter wrap on a CNT_W=4 copy.
module tb_logic_unit_pipe;

  logic CLK;
  logic RST;

  logic_unit_pipe_if #(.WIDTH(8), .CNT_W(16)) bus  ();
  logic_unit_pipe_if #(.WIDTH(8), .CNT_W(4))  bus4 ();

  logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) dut4 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus4.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  logic [2:0] v_op [32];
  logic [7:0] v_a  [32];
  logic [7:0] v_b  [32];
  logic [7:0] v_y  [32];
  logic [7:0] acc_m;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [7:0] ref_op(input logic [2:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic [7:0] acc);
    case (op)
      3'd0: return a & b;
      3'd1: return ~(a & b);
      3'd2: return a | b;
      3'd3: return ~(a | b);
      3'd4: return ~a;
      3'd5: return a ^ b;
      3'd6: return ~(a ^ b);
      default: return acc ^ a;
    endcase
  endfunction

  task automatic do_reset();
    RST = 1'b1;
    bus.IN_VALID = 1'b0;
    bus.OUT_READY = 1'b0;
    step();
    check("rst_in_ready_during", 64'(bus.IN_READY), 64'd1);
    step();
    RST = 1'b0;
    acc_m = 8'h00;
    check("rst_in_ready_after", 64'(bus.IN_READY), 64'd1);
    check("rst_out_valid", 64'(bus.OUT_VALID), 64'd0);
    check("rst_y", 64'(bus.Y), 64'd0);
    check("rst_zero", 64'(bus.ZERO), 64'd1);
    check("rst_parity", 64'(bus.PARITY), 64'd0);
    check("rst_count", 64'(bus.COUNT), 64'd0);
  endtask

  // Streams n vectors back to back with OUT_READY=1; result k must be valid
  // exactly two edges after the cycle in which op k was presented.
  task automatic run_seq(input string name, input int n, input int base_count);
    bus.OUT_READY = 1'b1;
    for (int c = 0; c <= n; c++) begin
      if (c < n) begin
        bus.IN_VALID = 1'b1;
        bus.A  = v_a[c];
        bus.B  = v_b[c];
        bus.OP = v_op[c];
        @(negedge CLK);
        check({name, "_in_ready"}, 64'(bus.IN_READY), 64'd1);
      end else begin
        bus.IN_VALID = 1'b0;
      end
      step();
      if (c >= 1) begin
        check({name, "_valid"},  64'(bus.OUT_VALID), 64'd1);
        check({name, "_y"},      64'(bus.Y), 64'(v_y[c-1]));
        check({name, "_zero"},   64'(bus.ZERO), 64'(v_y[c-1] == 8'h00));
        check({name, "_parity"}, 64'(bus.PARITY), 64'(^v_y[c-1]));
      end
    end
    step();
    check({name, "_drained"}, 64'(bus.OUT_VALID), 64'd0);
    check({name, "_count"}, 64'(bus.COUNT), 64'(base_count + n));
  endtask

  initial begin
    int sent;
    int got;
    int tr;

    RST = 1'b1;
    bus.IN_VALID = 1'b0;  bus.OUT_READY = 1'b0;
    bus.A = '0; bus.B = '0; bus.OP = '0;
    bus4.IN_VALID = 1'b0; bus4.OUT_READY = 1'b0;
    bus4.A = 8'h11; bus4.B = 8'h22; bus4.OP = 3'd5;
    acc_m = 8'h00;

    // Ops 0-6 on C5/3A
    do_reset();
    for (int i = 0; i < 7; i++) begin
      v_op[i] = 3'(i); v_a[i] = 8'hC5; v_b[i] = 8'h3A;
    end
    v_y[0] = 8'h00; v_y[1] = 8'hFF; v_y[2] = 8'hFF; v_y[3] = 8'h00;
    v_y[4] = 8'h3A; v_y[5] = 8'hFF; v_y[6] = 8'h00;
    run_seq("ops", 7, 0);

    // Accumulator sequence
    do_reset();
    for (int i = 0; i < 3; i++) begin
      v_op[i] = 3'd7; v_b[i] = 8'hAA;
    end
    v_a[0] = 8'h0F; v_a[1] = 8'hF0; v_a[2] = 8'hFF;
    v_y[0] = 8'h0F; v_y[1] = 8'hFF; v_y[2] = 8'h00;
    run_seq("acc", 3, 0);

    // Back-pressure: 4 ops, sink stalled for the first 5 cycles
    do_reset();
    v_op[0] = 3'd5; v_a[0] = 8'h12; v_b[0] = 8'h34; v_y[0] = 8'h26;
    v_op[1] = 3'd2; v_a[1] = 8'h0F; v_b[1] = 8'h30; v_y[1] = 8'h3F;
    v_op[2] = 3'd0; v_a[2] = 8'hF0; v_b[2] = 8'h3C; v_y[2] = 8'h30;
    v_op[3] = 3'd4; v_a[3] = 8'h55; v_b[3] = 8'h00; v_y[3] = 8'hAA;
    sent = 0;
    got = 0;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      bus.OUT_READY = (cyc >= 5);
      bus.IN_VALID  = (sent < 4);
      if (sent < 4) begin
        bus.A = v_a[sent]; bus.B = v_b[sent]; bus.OP = v_op[sent];
      end
      @(negedge CLK);
      if (cyc >= 2 && cyc <= 4) begin
        check("bp_in_ready_full", 64'(bus.IN_READY), 64'd0);
        check("bp_hold_valid", 64'(bus.OUT_VALID), 64'd1);
        check("bp_hold_y", 64'(bus.Y), 64'(v_y[0]));
      end
      if (bus.OUT_VALID && bus.OUT_READY) begin
        check("bp_order_y", 64'(bus.Y), 64'(v_y[got]));
        got++;
      end
      if (bus.IN_VALID && bus.IN_READY) sent++;
      step();
    end
    bus.IN_VALID = 1'b0;
    check("bp_results", 64'(got), 64'd4);
    check("bp_accepted", 64'(sent), 64'd4);
    check("bp_count", 64'(bus.COUNT), 64'd4);

    // 20 ops streamed with no bubbles
    do_reset();
    for (int i = 0; i < 20; i++) begin
      v_op[i] = 3'(i % 8);
      v_a[i]  = 8'(i * 37 + 5);
      v_b[i]  = 8'(i * 11) ^ 8'h5A;
      v_y[i]  = ref_op(v_op[i], v_a[i], v_b[i], acc_m);
      if (v_op[i] == 3'd7) acc_m = acc_m ^ v_a[i];
    end
    run_seq("stream", 20, 0);

    // Reset with both stages full and a nonzero accumulator
    bus.OUT_READY = 1'b1;
    bus.IN_VALID = 1'b1; bus.OP = 3'd7; bus.A = 8'h5A; bus.B = 8'h00;
    step();
    bus.IN_VALID = 1'b0;
    step();
    acc_m = acc_m ^ 8'h5A;
    bus.OUT_READY = 1'b0;
    bus.IN_VALID = 1'b1; bus.OP = 3'd0; bus.A = 8'hFF; bus.B = 8'h0F;
    @(negedge CLK);
    check("flush_acc_y", 64'(bus.Y), 64'(acc_m));
    step();
    @(negedge CLK);
    check("flush_full_in_ready", 64'(bus.IN_READY), 64'd0);
    check("flush_full_valid", 64'(bus.OUT_VALID), 64'd1);
    check("flush_count_before", 64'(bus.COUNT), 64'd20);
    RST = 1'b1;
    step();
    check("flush_out_valid", 64'(bus.OUT_VALID), 64'd0);
    check("flush_count", 64'(bus.COUNT), 64'd0);
    check("flush_in_ready", 64'(bus.IN_READY), 64'd1);
    RST = 1'b0;
    bus.IN_VALID = 1'b0;
    step();
    check("flush_no_ghost", 64'(bus.OUT_VALID), 64'd0);
    step();
    check("flush_no_ghost2", 64'(bus.OUT_VALID), 64'd0);
    v_op[0] = 3'd7; v_a[0] = 8'h01; v_b[0] = 8'hEE; v_y[0] = 8'h01;
    run_seq("post_rst_acc", 1, 0);

    // Counter wrap on the CNT_W=4 instance
    check("wrap_count_init", 64'(bus4.COUNT), 64'd0);
    bus4.IN_VALID = 1'b1;
    bus4.OUT_READY = 1'b1;
    tr = 0;
    for (int cyc = 0; cyc < 40 && tr < 17; cyc++) begin
      @(negedge CLK);
      if (bus4.OUT_VALID && bus4.OUT_READY) tr++;
      step();
      if (tr == 15 && bus4.OUT_VALID) check("wrap_count_15", 64'(bus4.COUNT), 64'd15);
      if (tr == 16) check("wrap_count_16", 64'(bus4.COUNT), 64'd0);
      if (tr == 17) check("wrap_count_17", 64'(bus4.COUNT), 64'd1);
    end
    bus4.IN_VALID = 1'b0;
    check("wrap_transfers", 64'(tr), 64'd17);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
